// File: rtl/jt12_sd_dec.sv
// Third-order CIC decimator: recovers signed PCM from a 1-bit sigma-delta stream.
// The output rate is the cen rate divided by 2**log2r.
//
// Ports:
//   clk        system clock
//   rst        synchronous, active-high reset (overrides cen)
//   cen        input-sample enable; din is consumed only when cen=1
//   din        sigma-delta bit, 1 -> +1, 0 -> -1
//   dout       signed decimated PCM sample, held between updates
//   dout_valid one-clk pulse when dout has just been updated with a settled sample
module jt12_sd_dec #(
  parameter int width = 12,
  parameter int log2r = 6
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cen,
  input  logic                    din,
  output logic signed [width-1:0] dout,
  output logic                    dout_valid
);

  localparam int W  = 3 * log2r + 2;
  localparam int SH = 3 * log2r + 1 - width;

  // Saturation bounds expressed at the internal width.
  localparam logic signed [W-1:0] SMAX = W'((2 ** (width - 1)) - 1);
  localparam logic signed [W-1:0] SMIN = ~SMAX;

  logic signed [W-1:0] i1, i2, i3;
  logic signed [W-1:0] z1, z2, z3;
  logic signed [W-1:0] x, d1, d2, d3, s;
  logic signed [width-1:0] sat;
  logic [log2r-1:0] cnt;
  logic [1:0]       prime;
  logic             dec_ev;

  always_comb begin
    x      = din ? W'(1) : '1;
    dec_ev = cen && (cnt == '1);
    // Comb runs off the pre-edge i3; only its value at a decimation event matters.
    d1     = i3 - z1;
    d2     = d1 - z2;
    d3     = d2 - z3;
    s      = d3 >>> SH;
    if (s > SMAX) begin
      sat = SMAX[width-1:0];
    end else if (s < SMIN) begin
      sat = SMIN[width-1:0];
    end else begin
      sat = s[width-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      i1         <= '0;
      i2         <= '0;
      i3         <= '0;
      z1         <= '0;
      z2         <= '0;
      z3         <= '0;
      cnt        <= '0;
      prime      <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
    end else begin
      dout_valid <= 1'b0;
      if (cen) begin
        // Integrators wrap modulo 2**W; the comb differences cancel the wrap.
        i1  <= i1 + x;
        i2  <= i2 + i1;
        i3  <= i3 + i2;
        cnt <= cnt + 1'b1;
        if (dec_ev) begin
          z1         <= i3;
          z2         <= d1;
          z3         <= d2;
          dout       <= sat;
          dout_valid <= (prime == 2'd3);
          if (prime != 2'd3) begin
            prime <= prime + 2'd1;
          end
        end
      end
    end
  end

endmodule
